// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per clock, fixed XLEN+1 cycle latency for every op.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      alu_control,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Low three bits of the op code, as latched at accept.
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHU  = 3'b010;
  localparam logic [2:0] OP_MULHSU = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic              neg_q;      // product / quotient must be negated
  logic              rem_neg_q;  // remainder takes the dividend's sign
  logic              b_zero_q;
  logic [XLEN-1:0]   mag_q;      // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] acc_q;      // {hi, lo}: product, or {remainder, quotient}
  logic [CW-1:0]     cnt_q;

  logic              accept, finish;
  logic              a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     add_sum, shifted, diff;
  logic [2*XLEN-1:0] mul_step, div_step, prod_fix;
  logic [XLEN-1:0]   quot, rem, final_result;

  assign accept = (state == IDLE) && start && !flush && (alu_control[4:3] == 2'b01);
  assign finish = (state == BUSY) && !flush && (cnt_q == LAST_CNT);

  // Operand sign decode for the incoming op.
  assign a_signed = (alu_control[2:0] != OP_MULHU) && (alu_control[2:0] != OP_DIVU) &&
                    (alu_control[2:0] != OP_REMU);
  assign b_signed = a_signed && (alu_control[2:0] != OP_MULHSU);
  assign sign_a   = a_signed && operand_a[XLEN-1];
  assign sign_b   = b_signed && operand_b[XLEN-1];
  assign mag_a    = sign_a ? -operand_a : operand_a;
  assign mag_b    = sign_b ? -operand_b : operand_b;

  // One multiply step: conditionally add multiplicand into hi, shift right.
  assign add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_step = {add_sum, acc_q[XLEN-1:1]};

  // One restoring divide step: shift next dividend bit into the remainder, try subtract.
  assign shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff     = shifted - {1'b0, mag_q};
  assign div_step = diff[XLEN] ? {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0],    acc_q[XLEN-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot     = acc_q[XLEN-1:0];
  assign rem      = acc_q[2*XLEN-1:XLEN];

  // Divide-by-zero remainder and signed overflow fall out of the magnitude datapath
  // exactly; only the signed divide-by-zero quotient needs an override.
  always_comb begin
    // NOTE: default first so no path leaves final_result unassigned (no latch).
    final_result = '0;
    unique case (op_q)
      OP_MUL:                       final_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU: final_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_result = b_zero_q ? '1 : (neg_q ? -quot : quot);
      OP_REM, OP_REMU:              final_result = rem_neg_q ? -rem : rem;
      default:                      final_result = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (flush) state_nxt = IDLE;
               else if (cnt_q == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every datapath register is reset, since result must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      mag_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result    <= '0;
    end else if (accept) begin
      op_q      <= alu_control[2:0];
      neg_q     <= sign_a ^ sign_b;
      rem_neg_q <= sign_a;
      b_zero_q  <= (operand_b == '0);
      mag_q     <= alu_control[2] ? mag_b : mag_a;
      acc_q     <= alu_control[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
      cnt_q     <= '0;
    end else if (finish) begin
      result    <= final_result;
    end else if (state == BUSY && !flush) begin
      acc_q     <= op_q[2] ? div_step : mul_step;
      cnt_q     <= cnt_q + 1'b1;
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes model results into a queue, a
// negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  localparam logic [4:0] MUL    = 5'b01000;
  localparam logic [4:0] MULH   = 5'b01001;
  localparam logic [4:0] MULHU  = 5'b01010;
  localparam logic [4:0] MULHSU = 5'b01011;
  localparam logic [4:0] DIV    = 5'b01100;
  localparam logic [4:0] DIVU   = 5'b01101;
  localparam logic [4:0] REM    = 5'b01110;
  localparam logic [4:0] REMU   = 5'b01111;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [4:0]  alu_control;
  logic [31:0] operand_a, operand_b;
  logic        busy, done;
  logic [31:0] result;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain 64-bit arithmetic from the RV32M rules.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      REM:    begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      DIVU:   begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      REMU:   begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_done", {63'd0, done}, 64'd0);
      else check("result", {32'd0, result}, {32'd0, exp_q.pop_front()});
    end
  end

  // Issue one op; optionally re-pulse start with fresh operands at T+5.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit repulse);
    int cycles, busy_gaps;
    @(negedge clk);
    start = 1'b1; alu_control = op; operand_a = a; operand_b = b;
    exp_q.push_back(model(op, a, b));
    last_result = model(op, a, b);
    @(posedge clk); #1;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom; alu_control = 5'($urandom);
    cycles = 0; busy_gaps = 0;
    while (done !== 1'b1 && cycles < 100) begin
      if (repulse && cycles == 4) begin
        start = 1'b1; alu_control = MUL; operand_a = $urandom; operand_b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
      if (done !== 1'b1 && busy !== 1'b1) busy_gaps++;
    end
    start = 1'b0;
    check("latency", 64'(cycles), 64'd33);
    check("busy_continuous", 64'(busy_gaps), 64'd0);
    check("busy_low_at_done", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  // Watch a quiet window; returns how many cycles showed done or busy.
  task automatic quiet_window(input int n, output int done_cnt, output int busy_cnt);
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  ops[8];
    logic [4:0]  op;
    logic [31:0] a, b;
    int dc, bc;
    ops = '{MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM, REMU};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    alu_control = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    rst_n = 1'b1;

    run_op(MUL,    32'd7,          32'hFFFF_FFFD, 1'b0);
    run_op(MULH,   32'h8000_0000,  32'h8000_0000, 1'b0);
    run_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
    run_op(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
    run_op(DIV,    32'hFFFF_FFF9,  32'd2,         1'b0);
    run_op(REM,    32'hFFFF_FFF9,  32'd2,         1'b0);
    run_op(DIVU,   32'hFFFF_FFFE,  32'd2,         1'b0);
    run_op(REMU,   32'd7,          32'd2,         1'b0);
    run_op(DIV,    32'd5,          32'd0,         1'b0);
    run_op(REMU,   32'd5,          32'd0,         1'b0);
    run_op(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
    run_op(REM,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
    run_op(MUL,    32'd1234,       32'd5678,      1'b1);

    // Unsupported op code: nothing happens.
    @(negedge clk);
    start = 1'b1; alu_control = 5'b00001; operand_a = 32'd3; operand_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    check("illegal_op_busy", {63'd0, busy}, 64'd0);
    quiet_window(40, dc, bc);
    check("illegal_op_no_done", 64'(dc), 64'd0);
    check("illegal_op_no_busy", 64'(bc), 64'd0);
    check("illegal_op_result_held", {32'd0, result}, {32'd0, last_result});

    // Flush together with start in IDLE blocks the accept.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; alu_control = DIV; operand_a = 32'd9; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {63'd0, busy}, 64'd0);

    // Flush mid-operation at T+10.
    @(negedge clk);
    start = 1'b1; alu_control = MULHU; operand_a = $urandom; operand_b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    quiet_window(40, dc, bc);
    check("flush_no_done", 64'(dc), 64'd0);
    check("flush_result_held", {32'd0, result}, {32'd0, last_result});

    // Reset at T+20 aborts the op and clears the result.
    @(negedge clk);
    start = 1'b1; alu_control = DIVU; operand_a = $urandom; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midop_reset_busy", {63'd0, busy}, 64'd0);
    check("midop_reset_done", {63'd0, done}, 64'd0);
    check("midop_reset_result", {32'd0, result}, 64'd0);
    rst_n = 1'b1;
    last_result = '0;
    quiet_window(40, dc, bc);
    check("midop_reset_no_done", 64'(dc), 64'd0);

    // Randomized ops with biased special operands.
    for (int i = 0; i < 48; i++) begin
      op = ops[$urandom_range(7)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(15));
        default: ;
      endcase
      run_op(op, a, b, ($urandom_range(3) == 0));
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
